// File: rtl/spi_slave_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_port
//
// Mode-0 (CPOL=0, CPHA=0) SPI responder for the host MCU link. SCK, NCS and
// MOSI are oversampled in the clk domain. Received words are handed to the
// command decoder on rx_data/rx_valid. A single-entry reply buffer is shifted
// out on MISO, MSB first.
//
// Configuration macro: SPI_SLAVE_MISO_TRISTATE_EN
//   defined   : spi_slave_miso is inout. It is driven only while a frame is
//               active and is Z otherwise, so MISO can be shared.
//   undefined : spi_slave_miso is a plain output, held at 0 outside a frame.
//
// Parameters:
//   DATA_WIDTH  bits per SPI word (2 or more)
//   SYNC_STAGES synchronizer depth on SCK/NCS/MOSI (2 or more)
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   spi_slave_sck/mosi/ncs  host SPI pins (asynchronous to clk)
//   spi_slave_miso      reply data to host
//   tx_data, tx_load    reply word and its write strobe
//   tx_ready            reply buffer empty
//   tx_underrun         pulse: a word started shifting with the buffer empty
//   rx_data, rx_valid   last complete received word and its update pulse
//   frame_active        synced NCS is low
//   frame_start/done    pulses on synced NCS falling/rising edge
// -----------------------------------------------------------------------------
module spi_slave_port #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_slave_sck,
   input  logic                  spi_slave_mosi,
   input  logic                  spi_slave_ncs,
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   inout  wire                   spi_slave_miso,
`else
   output logic                  spi_slave_miso,
`endif
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_active,
   output logic                  frame_start,
   output logic                  frame_done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0]  ncs_sync_q, ncs_sync_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
   logic                    sck_hist_q, sck_hist_d;
   logic                    ncs_hist_q, ncs_hist_d;
   logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                    word_boundary_q, word_boundary_d;
   logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic                    rx_pending_q, rx_pending_d;
   logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
   logic                    tx_ready_q, tx_ready_d;
   logic                    tx_underrun_q, tx_underrun_d;
   logic                    frame_active_q, frame_active_d;
   logic                    frame_start_q, frame_start_d;
   logic                    frame_done_q, frame_done_d;
   logic                    miso_q, miso_d;

   logic sck_s, ncs_s, mosi_s;
   logic sck_rise_s, sck_fall_s, ncs_rise_s, ncs_fall_s;
   logic load_evt_s, consume_s;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sck_rise_s = sck_s & ~sck_hist_q;
   assign sck_fall_s = ~sck_s & sck_hist_q;
   assign ncs_fall_s = ~ncs_s & ncs_hist_q;
   assign ncs_rise_s = ncs_s & ~ncs_hist_q;

   // Synchronizer and edge-history next state
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_slave_sck};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi_slave_ncs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_slave_mosi};
      sck_hist_d  = sck_s;
      ncs_hist_d  = ncs_s;
   end

   // Frame FSM, shift registers and reply buffer next state
   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      word_boundary_d = word_boundary_q;
      rx_shift_d      = rx_shift_q;
      rx_pending_d    = 1'b0;
      rx_data_d       = rx_data_q;
      rx_valid_d      = 1'b0;
      tx_shift_d      = tx_shift_q;
      tx_buf_d        = tx_buf_q;
      tx_ready_d      = tx_ready_q;
      tx_underrun_d   = 1'b0;
      frame_start_d   = 1'b0;
      frame_done_d    = 1'b0;
      frame_active_d  = ~ncs_s;
      load_evt_s      = 1'b0;
      consume_s       = 1'b0;

      // The word completed on the previous cycle is published one cycle later.
      if (rx_pending_q) begin
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
      end else begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            bit_cnt_d       = {CW{1'b0}};
            word_boundary_d = 1'b0;
            if (ncs_fall_s) begin
               state_d       = ACTIVE;
               frame_start_d = 1'b1;
               load_evt_s    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            // NCS rising wins over any SCK edge seen in the same cycle.
            if (ncs_rise_s) begin
               state_d         = IDLE;
               frame_done_d    = 1'b1;
               bit_cnt_d       = {CW{1'b0}};
               word_boundary_d = 1'b0;
               rx_shift_d      = {DATA_WIDTH{1'b0}};
            end else begin
               if (sck_rise_s) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                  if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                     bit_cnt_d       = {CW{1'b0}};
                     word_boundary_d = 1'b1;
                     rx_pending_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q;
               end
               if (sck_fall_s) begin
                  if (word_boundary_q) begin
                     load_evt_s      = 1'b1;
                     word_boundary_d = 1'b0;
                  end else begin
                     tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end else begin
                  tx_shift_d = tx_shift_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Shift register load: take the buffered word, or zeros on underrun.
      if (load_evt_s) begin
         if (tx_ready_q) begin
            tx_shift_d    = {DATA_WIDTH{1'b0}};
            tx_underrun_d = 1'b1;
         end else begin
            tx_shift_d = tx_buf_q;
            consume_s  = 1'b1;
         end
      end else begin
         consume_s = 1'b0;
      end

      // A load arriving with a consume refills the slot the consume frees.
      if (tx_load && (tx_ready_q || consume_s)) begin
         tx_buf_d   = tx_data;
         tx_ready_d = 1'b0;
      end else if (consume_s) begin
         tx_ready_d = 1'b1;
      end else begin
         tx_ready_d = tx_ready_q;
      end
   end

   // MISO data follows the shift register MSB only while a frame is active
   always_comb begin
      if (state_q == ACTIVE) begin
         miso_d = tx_shift_q[DATA_WIDTH-1];
      end else begin
         miso_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         sck_sync_q      <= {SYNC_STAGES{1'b0}};
         ncs_sync_q      <= {SYNC_STAGES{1'b1}};
         mosi_sync_q     <= {SYNC_STAGES{1'b0}};
         sck_hist_q      <= 1'b0;
         ncs_hist_q      <= 1'b1;
         bit_cnt_q       <= {CW{1'b0}};
         word_boundary_q <= 1'b0;
         rx_shift_q      <= {DATA_WIDTH{1'b0}};
         rx_pending_q    <= 1'b0;
         rx_data_q       <= {DATA_WIDTH{1'b0}};
         rx_valid_q      <= 1'b0;
         tx_shift_q      <= {DATA_WIDTH{1'b0}};
         tx_buf_q        <= {DATA_WIDTH{1'b0}};
         tx_ready_q      <= 1'b1;
         tx_underrun_q   <= 1'b0;
         frame_active_q  <= 1'b0;
         frame_start_q   <= 1'b0;
         frame_done_q    <= 1'b0;
         miso_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         sck_sync_q      <= sck_sync_d;
         ncs_sync_q      <= ncs_sync_d;
         mosi_sync_q     <= mosi_sync_d;
         sck_hist_q      <= sck_hist_d;
         ncs_hist_q      <= ncs_hist_d;
         bit_cnt_q       <= bit_cnt_d;
         word_boundary_q <= word_boundary_d;
         rx_shift_q      <= rx_shift_d;
         rx_pending_q    <= rx_pending_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         tx_shift_q      <= tx_shift_d;
         tx_buf_q        <= tx_buf_d;
         tx_ready_q      <= tx_ready_d;
         tx_underrun_q   <= tx_underrun_d;
         frame_active_q  <= frame_active_d;
         frame_start_q   <= frame_start_d;
         frame_done_q    <= frame_done_d;
         miso_q          <= miso_d;
      end
   end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   logic miso_oe_q, miso_oe_d;

   // Output enable tracks the frame state, registered alongside MISO data
   always_comb begin
      if (state_q == ACTIVE) begin
         miso_oe_d = 1'b1;
      end else begin
         miso_oe_d = 1'b0;
      end
   end

   // Output enable register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miso_oe_q <= 1'b0;
      end else begin
         miso_oe_q <= miso_oe_d;
      end
   end

   assign spi_slave_miso = miso_oe_q ? miso_q : 1'bz;
`else
   assign spi_slave_miso = miso_q;
`endif

   assign tx_ready     = tx_ready_q;
   assign tx_underrun  = tx_underrun_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign frame_active = frame_active_q;
   assign frame_start  = frame_start_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_spi_slave_port.sv
`timescale 1ns/1ps
// Testbench for spi_slave_port: an SPI host model drives frames, a scoreboard
// queue holds the words the decoder side should see, and a monitor process
// pops and compares on every rx_valid pulse.
module tb_spi_slave_port;

   localparam int W = 8;
   localparam int H = 6;   // SCK half period in clk cycles

   logic       clk = 1'b0;
   logic       reset, sck, mosi, ncs, tx_load;
   logic [7:0] tx_data, rx_data;
   logic       tx_ready, tx_underrun, rx_valid, frame_active, frame_start, frame_done;
   wire        miso;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_ur  = 0;
   int cnt_fs  = 0;
   int cnt_fd  = 0;
   bit host_done;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic [7:0] feed_q[$];
   logic [7:0] mosi_words[$];
   logic [7:0] tx_words[$];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   localparam logic MISO_IDLE = 1'bz;
`else
   localparam logic MISO_IDLE = 1'b0;
`endif

   spi_slave_port #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .spi_slave_sck(sck), .spi_slave_mosi(mosi), .spi_slave_ncs(ncs),
      .spi_slave_miso(miso),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_active(frame_active), .frame_start(frame_start), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: compares each published word, counts pulses.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (rx_valid) begin
               if (exp_rx.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
               else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
            if (tx_underrun) cnt_ur++;
            if (frame_start) cnt_fs++;
            if (frame_done)  cnt_fd++;
         end
      end
   endtask

   // SPI host: n_full whole words then 'part' extra bits. The last SCK fall
   // coincides with NCS rising, so no trailing reload happens.
   task automatic host(input int n_full, input int part);
      int nbits = n_full * W + part;
      logic [7:0] acc = 8'h00;
      logic [7:0] ew;
      int nb;
      @(negedge clk);
      ncs = 1'b0;
      if (nbits == 0) begin
         repeat (H) @(negedge clk);
         chk("frame_active_on", {31'h0, frame_active}, 32'h1);
         ncs = 1'b1;
      end
      for (int b = 0; b < nbits; b++) begin
         mosi = mosi_words[b / W][W - 1 - (b % W)];
         repeat (H) @(negedge clk);
         if (b == 0) chk("frame_active_on", {31'h0, frame_active}, 32'h1);
         acc = {acc[6:0], miso};
         sck = 1'b1;
         repeat (H) @(negedge clk);
         sck = 1'b0;
         if (b == nbits - 1) ncs = 1'b1;
         if ((b % W) == W - 1 || b == nbits - 1) begin
            nb = (b % W) + 1;
            ew = exp_miso.pop_front();
            chk("miso_word", {24'h0, acc & (8'hFF >> (W - nb))}, {24'h0, ew >> (W - nb)});
         end
      end
      repeat (2 * H) @(negedge clk);
      chk("frame_active_off", {31'h0, frame_active}, 32'h0);
      host_done = 1'b1;
   endtask

   // Reference model: each started word (at least one per frame) consumes
   // one reply word in order, or zeros with an underrun when none is left.
   task automatic frame(input int n_full, input int part, input bit pre, input logic [7:0] pre_word);
      int started, loads, ur0, fs0, fd0;
      logic [7:0] src[$];
      started = n_full + ((part > 0) ? 1 : 0);
      loads   = (started == 0) ? 1 : started;
      src = {};
      if (pre) src.push_back(pre_word);
      foreach (tx_words[i]) src.push_back(tx_words[i]);
      for (int j = 0; j < n_full; j++) exp_rx.push_back(mosi_words[j]);
      for (int j = 0; j < started; j++) exp_miso.push_back((j < src.size()) ? src[j] : 8'h00);
      feed_q = tx_words;
      ur0 = cnt_ur; fs0 = cnt_fs; fd0 = cnt_fd;
      host_done = 1'b0;
      fork
         begin
            repeat (3) @(negedge clk);
            host(n_full, part);
         end
         begin
            while (!host_done) begin
               @(negedge clk);
               tx_load = 1'b0;
               if (tx_ready && feed_q.size() > 0) begin
                  tx_data = feed_q.pop_front();
                  tx_load = 1'b1;
               end
            end
            tx_load = 1'b0;
         end
      join
      chk("underruns", cnt_ur - ur0, loads - src.size());
      chk("frame_start_cnt", cnt_fs - fs0, 32'd1);
      chk("frame_done_cnt", cnt_fd - fd0, 32'd1);
      chk("rx_missing", exp_rx.size(), 32'd0);
      chk("tx_ready_end", {31'h0, tx_ready}, 32'h1);
      if (n_full > 0) chk("rx_hold", {24'h0, rx_data}, {24'h0, mosi_words[n_full - 1]});
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h1);
      chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
      chk({tag, "_pulses"}, {27'h0, rx_valid, tx_underrun, frame_start, frame_done, frame_active}, 32'h0);
      chk({tag, "_miso"}, {31'h0, miso}, {31'h0, MISO_IDLE});
   endtask

   initial begin
      int nf, pt, st, ld, ntx, fs0;
      reset = 1'b1; sck = 1'b0; ncs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      reset = 1'b0;
      fork monitor(); join_none
      repeat (3) @(negedge clk);

      // Single word
      mosi_words = {8'hA5}; tx_words = {8'h3C};
      frame(1, 0, 1'b0, 8'h00);

      // Back-to-back words
      mosi_words = {8'hF0, 8'h0F}; tx_words = {8'h11, 8'h22};
      frame(2, 0, 1'b0, 8'h00);

      // Underrun: empty buffer over a 2-word frame
      mosi_words = {8'h81, 8'h7E}; tx_words = {};
      frame(2, 0, 1'b0, 8'h00);

      // Load while full is ignored
      @(negedge clk); tx_data = 8'h66; tx_load = 1'b1;
      @(negedge clk); tx_data = 8'h99;
      chk("tx_ready_after_load", {31'h0, tx_ready}, 32'h0);
      @(negedge clk); tx_load = 1'b0;
      mosi_words = {8'h42}; tx_words = {};
      frame(1, 0, 1'b1, 8'h66);

      // Aborted word then a clean word
      mosi_words = {8'hFF}; tx_words = {};
      frame(0, 5, 1'b0, 8'h00);
      mosi_words = {8'h5A}; tx_words = {8'hE7};
      frame(1, 0, 1'b0, 8'h00);

      // Mid-frame reset after 3 bits
      @(negedge clk); ncs = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mosi = b[0];
         repeat (H) @(negedge clk);
         sck = 1'b1;
         repeat (H) @(negedge clk);
         sck = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b1; ncs = 1'b1;
      repeat (3) @(negedge clk);
      reset_checks("midreset");
      fs0 = cnt_fs;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_spurious_start", cnt_fs - fs0, 32'd0);
      mosi_words = {8'hC3}; tx_words = {};
      frame(1, 0, 1'b0, 8'h00);

      // Randomized frames
      for (int r = 0; r < 20; r++) begin
         nf = $urandom_range(0, 3);
         pt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
         st = nf + ((pt > 0) ? 1 : 0);
         ld = (st == 0) ? 1 : st;
         ntx = $urandom_range(0, ld);
         mosi_words = {};
         tx_words = {};
         for (int j = 0; j < st; j++) mosi_words.push_back(8'($urandom));
         for (int j = 0; j < ntx; j++) tx_words.push_back(8'($urandom));
         frame(nf, pt, 1'b0, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
